// File: rtl/ext_alu_responder.sv
// ext_alu_responder
//   Responder side of a strobe-handshaked external ALU. The initiator presents
//   OP1 and ALUOP with CSR_ALU_IN[1]. It then presents OP2 with CSR_ALU_IN[2].
//   The responder computes the result and shows it on OP3 with CSR_ALU_OUT[2].
//   The result stays there until the initiator raises and then drops
//   CSR_ALU_IN[0] (result protect).
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   ALUOP[3:0]   opcode, captured together with OP1
//   OP1[31:0]    first operand
//   OP2[31:0]    second operand
//   CSR_ALU_IN   [0] result protect, [1] OP1 valid, [2] OP2 valid
//   CSR_ALU_OUT  [0] ready for OP1, [1] ready for OP2, [2] result valid
//   OP3[31:0]    registered result
//
// Parameter
//   LATENCY      edges from OP2 capture to result for non-iterative ops (1..15)
module ext_alu_responder #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ALUOP,
    input  logic [31:0] OP1,
    input  logic [31:0] OP2,
    input  logic [2:0]  CSR_ALU_IN,
    output logic [2:0]  CSR_ALU_OUT,
    output logic [31:0] OP3
);

    typedef enum logic [1:0] {WAIT_OP1, WAIT_OP2, COMPUTE, DONE} state_t;

    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;

    state_t      state_reg;
    logic [2:0]  csr_out_reg;
    logic [31:0] op3_reg;
    logic [3:0]  aluop_reg;
    logic [31:0] op1_reg;
    logic [31:0] op2_reg;
    logic [4:0]  count_reg;
    logic        seen_protect_reg;

    // Iterative datapath shared by MUL and DIVU:
    //   MUL : work_a = shifted multiplicand, work_b = shifted multiplier, acc = partial sum
    //   DIVU: work_a = dividend shifting out / quotient shifting in,
    //         work_b = divisor, acc = partial remainder
    logic [31:0] work_a_reg;
    logic [31:0] work_b_reg;
    logic [31:0] acc_reg;

    logic        is_iter;
    logic        is_mul;
    logic        last_cycle;
    logic [31:0] mul_acc_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem_next;
    logic [31:0] div_quot_next;
    logic [31:0] simple_result;
    logic [31:0] final_result;

    assign is_mul  = (aluop_reg == OP_MUL);
    assign is_iter = is_mul || (aluop_reg == OP_DIVU);

    // Iterative ops finish on their 32nd step. All other ops finish after LATENCY edges.
    assign last_cycle = is_iter ? (count_reg == 5'd31)
                                : (count_reg == 5'(LATENCY - 1));

    // One shift-add multiply step.
    assign mul_acc_next = acc_reg + (work_b_reg[0] ? work_a_reg : 32'd0);

    // One restoring-divide step. Bit 32 of the difference is the borrow.
    // With a zero divisor there is never a borrow, so the quotient fills with ones.
    assign div_shift     = {acc_reg, work_a_reg[31]};
    assign div_diff      = div_shift - {1'b0, work_b_reg};
    assign div_ge        = ~div_diff[32];
    assign div_rem_next  = div_ge ? div_diff[31:0] : div_shift[31:0];
    assign div_quot_next = {work_a_reg[30:0], div_ge};

    always_comb begin
        simple_result = 32'd0;
        case (aluop_reg)
            4'd0: simple_result = op1_reg + op2_reg;
            4'd1: simple_result = op1_reg - op2_reg;
            4'd2: simple_result = op1_reg & op2_reg;
            4'd3: simple_result = op1_reg | op2_reg;
            4'd4: simple_result = op1_reg ^ op2_reg;
            4'd5: simple_result = op1_reg << op2_reg[4:0];
            4'd6: simple_result = op1_reg >> op2_reg[4:0];
            4'd7: simple_result = $unsigned($signed(op1_reg) >>> op2_reg[4:0]);
            4'd8: simple_result = {31'd0, $signed(op1_reg) < $signed(op2_reg)};
            4'd9: simple_result = {31'd0, op1_reg < op2_reg};
            default: simple_result = 32'd0;
        endcase
    end

    always_comb begin
        final_result = simple_result;
        if (is_iter) begin
            final_result = is_mul ? mul_acc_next : div_quot_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= WAIT_OP1;
            csr_out_reg      <= 3'b001;
            op3_reg          <= 32'd0;
            aluop_reg        <= 4'd0;
            op1_reg          <= 32'd0;
            op2_reg          <= 32'd0;
            count_reg        <= 5'd0;
            seen_protect_reg <= 1'b0;
            work_a_reg       <= 32'd0;
            work_b_reg       <= 32'd0;
            acc_reg          <= 32'd0;
        end else begin
            case (state_reg)
                WAIT_OP1: begin
                    if (CSR_ALU_IN[1]) begin
                        op1_reg     <= OP1;
                        aluop_reg   <= ALUOP;
                        state_reg   <= WAIT_OP2;
                        csr_out_reg <= 3'b010;
                    end
                end
                WAIT_OP2: begin
                    if (CSR_ALU_IN[2]) begin
                        op2_reg     <= OP2;
                        work_a_reg  <= op1_reg;
                        work_b_reg  <= OP2;
                        acc_reg     <= 32'd0;
                        count_reg   <= 5'd0;
                        state_reg   <= COMPUTE;
                        csr_out_reg <= 3'b000;
                    end
                end
                COMPUTE: begin
                    count_reg <= count_reg + 5'd1;
                    if (is_mul) begin
                        acc_reg    <= mul_acc_next;
                        work_a_reg <= work_a_reg << 1;
                        work_b_reg <= work_b_reg >> 1;
                    end else if (is_iter) begin
                        acc_reg    <= div_rem_next;
                        work_a_reg <= div_quot_next;
                    end
                    if (last_cycle) begin
                        op3_reg          <= final_result;
                        seen_protect_reg <= 1'b0;
                        state_reg        <= DONE;
                        csr_out_reg      <= 3'b100;
                    end
                end
                DONE: begin
                    if (seen_protect_reg && !CSR_ALU_IN[0]) begin
                        seen_protect_reg <= 1'b0;
                        state_reg        <= WAIT_OP1;
                        csr_out_reg      <= 3'b001;
                    end else if (CSR_ALU_IN[0]) begin
                        seen_protect_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= WAIT_OP1;
                    csr_out_reg <= 3'b001;
                end
            endcase
        end
    end

    assign CSR_ALU_OUT = csr_out_reg;
    assign OP3         = op3_reg;

endmodule
